ysyx_25040109_lsu_mc: RTL and testbench

//  Multi-cycle, handshaked load/store unit between EXU and the data-memory bus; parametrised successor of the single-cycle LSU.

---
 rtl/ysyx_25040109_lsu_pkg.sv | 53 +++++
 rtl/ysyx_25040109_lsu_align.sv | 62 ++++++
 rtl/ysyx_25040109_lsu_mc.sv | 148 ++++++++++++++
 tb/tb_ysyx_25040109_lsu_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit.
//   - RISC-V funct3 encodings for loads and stores
//   - FSM state encoding (2 bits)
//   - helpers for strobe width, lane-offset width, size masks and
//     the illegal-funct3 rule (which depends on XLEN)
package ysyx_25040109_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    function automatic int lsu_strb_w(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int lsu_off_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] lsu_size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Doubleword and LWU only exist on RV64; 111 is never legal.
    function automatic logic lsu_f3_illegal(input logic [2:0] funct3, input int xlen);
        if (xlen == 64)
            return funct3 == 3'b111;
        return (funct3 == F3_LD) || (funct3 == F3_LWU) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational lane alignment for the LSU.
//   Write side: byte strobes from size/offset and store data shifted
//               into its byte lanes.
//   Read side : bus word shifted down by the lane offset, then
//               sign/zero-extended according to funct3.
// Ports:
//   wr_size  [1:0]    access size (funct3[1:0])
//   wr_off   OFF_W    byte lane offset of the access
//   wr_wdata XLEN     LSB-justified store data
//   wr_strb  STRB_W   byte strobes
//   wr_data  XLEN     lane-shifted store data
//   rd_funct3 [2:0]   captured load funct3
//   rd_off   OFF_W    captured lane offset
//   rd_rdata XLEN     full-width bus read word
//   rd_data  XLEN     extended load result
module ysyx_25040109_lsu_align
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int STRB_W = lsu_strb_w(XLEN),
    localparam int OFF_W  = lsu_off_w(XLEN)
) (
    input  logic [1:0]        wr_size,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [XLEN-1:0]   wr_wdata,
    output logic [STRB_W-1:0] wr_strb,
    output logic [XLEN-1:0]   wr_data,
    input  logic [2:0]        rd_funct3,
    input  logic [OFF_W-1:0]  rd_off,
    input  logic [XLEN-1:0]   rd_rdata,
    output logic [XLEN-1:0]   rd_data
);

    logic [STRB_W-1:0] strb_base;
    logic [XLEN-1:0]   shifted;

    always_comb begin
        strb_base = '0;
        case (wr_size)
            2'd0:    strb_base = STRB_W'(1);
            2'd1:    strb_base = STRB_W'(3);
            2'd2:    strb_base = STRB_W'(15);
            default: strb_base = '1;
        endcase
        wr_strb = strb_base << wr_off;
        wr_data = wr_wdata << {wr_off, 3'b000};
    end

    always_comb begin
        shifted = rd_rdata >> {rd_off, 3'b000};
        case (rd_funct3)
            F3_LB:   rd_data = XLEN'(signed'(shifted[7:0]));
            F3_LH:   rd_data = XLEN'(signed'(shifted[15:0]));
            F3_LW:   rd_data = XLEN'(signed'(shifted[31:0]));
            F3_LBU:  rd_data = XLEN'(shifted[7:0]);
            F3_LHU:  rd_data = XLEN'(shifted[15:0]);
            F3_LWU:  rd_data = XLEN'(shifted[31:0]);
            default: rd_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu_mc.sv
// Multi-cycle handshaked load/store unit between EXU and the data bus.
// One access outstanding; request -> one bus transaction -> result to WBU.
//
// Configuration macro: YSYX_25040109_LSU_MISALIGN_CHK_EN
//   defined   : misaligned accesses complete immediately with rsp_err=1
//   undefined : lane offset is forced down to natural alignment
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      EXU request handshake
//   req_addr/wdata/funct3/is_store   request payload
//   mem_req_valid/ready      bus request handshake
//   mem_req_addr/wen/wstrb/wdata     bus request payload (word aligned)
//   mem_rsp_valid/rdata/err  bus response (always accepted in WAIT)
//   rsp_valid/ready          WBU result handshake
//   rsp_data/rsp_err         extended load data (0 for stores) and error
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | ready for a new access
// REQ   | bus request presented, waiting for mem_req_ready
// WAIT  | waiting for mem_rsp_valid
// RESP  | result held for WBU until rsp_ready
module ysyx_25040109_lsu_mc
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [2:0]          req_funct3,
    input  logic                req_is_store,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    output logic [XLEN-1:0]     mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_err
);

    localparam int OFF_W = lsu_off_w(XLEN);

    lsu_state_t state, state_nxt;

    logic [2:0]          funct3_q;
    logic [OFF_W-1:0]    off_q;
    logic                store_q;

    logic                accept;
    logic [OFF_W-1:0]    off_raw;
    logic [OFF_W-1:0]    size_mask;
    logic [OFF_W-1:0]    off_eff;
    logic                access_bad;
    logic [XLEN/8-1:0]   wr_strb;
    logic [XLEN-1:0]     wr_data;
    logic [XLEN-1:0]     rd_data;

    assign accept    = req_valid && req_ready;
    assign off_raw   = req_addr[OFF_W-1:0];
    assign size_mask = OFF_W'(lsu_size_mask(req_funct3[1:0]));

`ifdef YSYX_25040109_LSU_MISALIGN_CHK_EN
    assign off_eff    = off_raw;
    assign access_bad = lsu_f3_illegal(req_funct3, XLEN) || (|(off_raw & size_mask));
`else
    // Drop the sub-size offset bits so the access lands on its natural boundary.
    assign off_eff    = off_raw & ~size_mask;
    assign access_bad = lsu_f3_illegal(req_funct3, XLEN);
`endif

    ysyx_25040109_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .wr_size   (req_funct3[1:0]),
        .wr_off    (off_eff),
        .wr_wdata  (req_wdata),
        .wr_strb   (wr_strb),
        .wr_data   (wr_data),
        .rd_funct3 (funct3_q),
        .rd_off    (off_q),
        .rd_rdata  (mem_rsp_rdata),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid)     state_nxt = access_bad ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)     state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == ST_IDLE);
        mem_req_valid = (state == ST_REQ);
        mem_req_wen   = (state == ST_REQ) && store_q;
        rsp_valid     = (state == ST_RESP);
    end

    // Bus payload is built once at accept so it stays stable through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q      <= '0;
            off_q         <= '0;
            store_q       <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wstrb <= '0;
            mem_req_wdata <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else if (accept) begin
            funct3_q      <= req_funct3;
            off_q         <= off_eff;
            store_q       <= req_is_store;
            mem_req_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wstrb <= wr_strb;
            mem_req_wdata <= req_is_store ? wr_data : '0;
            rsp_data      <= '0;
            rsp_err       <= access_bad;
        end else if (state == ST_WAIT && mem_rsp_valid) begin
            rsp_data      <= (mem_rsp_err || store_q) ? '0 : rd_data;
            rsp_err       <= mem_rsp_err;
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_lsu_mc.sv
module tb_ysyx_25040109_lsu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_data;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_is_store = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic [63:0] b_req_wdata = '0;
    logic [2:0]  b_req_funct3 = '0;
    logic        b_mem_req_valid, b_mem_req_ready = 1'b0, b_mem_req_wen;
    logic [31:0] b_mem_req_addr;
    logic [63:0] b_mem_req_wdata;
    logic [7:0]  b_mem_req_wstrb;
    logic        b_mem_rsp_valid = 1'b0, b_mem_rsp_err = 1'b0;
    logic [63:0] b_mem_rsp_rdata = '0;
    logic        b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err;
    logic [63:0] b_rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_25040109_lsu_mc #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_is_store(req_is_store),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    ysyx_25040109_lsu_mc #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_funct3(b_req_funct3), .req_is_store(b_req_is_store),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_addr(b_mem_req_addr),
        .mem_req_wen(b_mem_req_wen), .mem_req_wstrb(b_mem_req_wstrb), .mem_req_wdata(b_mem_req_wdata),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rsp_rdata), .mem_rsp_err(b_mem_rsp_err),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
    );

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit m_bad(input logic [2:0] f3, input logic [31:0] addr, input int xlen);
        if (xlen == 32 && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (xlen == 64 && f3 == 7) return 1'b1;
`ifdef YSYX_25040109_LSU_MISALIGN_CHK_EN
        if ((addr % m_size(f3)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] addr, input int xlen);
        int unsigned o;
        o = addr % (xlen / 8);
`ifndef YSYX_25040109_LSU_MISALIGN_CHK_EN
        o = o - (o % m_size(f3));
`endif
        return o;
    endfunction

    function automatic longint unsigned m_strb(input logic [2:0] f3, input int unsigned off);
        return ((64'd1 << m_size(f3)) - 64'd1) << off;
    endfunction

    function automatic longint unsigned m_load(input logic [2:0] f3, input longint unsigned word, input int unsigned off);
        longint unsigned v, lim;
        int unsigned bits;
        v = word >> (8 * off);
        bits = 8 * m_size(f3);
        if (bits == 64) return v;
        lim = 64'd1 << bits;
        v = v % lim;
        if (f3 < 4 && v >= (lim >> 1)) v = v - lim;
        return v;
    endfunction

    // ---------------- XLEN=32 access driver with inline checks ----------------
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword, input bit berr,
                          input int stall, input int lat, input int hold, input string tag);
        bit          bad;
        int unsigned off;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_data, e_addr;
        bit          e_err;
        bad     = m_bad(f3, addr, 32);
        off     = m_off(f3, addr, 32);
        e_strb  = 4'(m_strb(f3, off));
        e_wdata = 32'(64'(wdata) << (8 * off));
        e_data  = (st || berr || bad) ? 32'h0 : 32'(m_load(f3, 64'(rword), off));
        e_err   = bad || berr;
        e_addr  = addr & 32'hFFFF_FFFC;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_ready: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_is_store = 1'($urandom);

        if (!bad) begin
            for (int i = 0; i <= stall; i++) begin
                mem_req_ready = (i == stall);
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== e_addr || mem_req_wstrb !== e_strb ||
                    mem_req_wen !== st || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus_req[%0d]: valid=%b addr=%h strb=%h wen=%b rv=%b want 1 %h %h %b 0",
                             tag, i, mem_req_valid, mem_req_addr, mem_req_wstrb, mem_req_wen, rsp_valid,
                             e_addr, e_strb, st);
                end
                if (st) begin
                    checks++;
                    if (mem_req_wdata !== e_wdata) begin
                        errors++; $display("FAIL %s bus_wdata: got %h want %h", tag, mem_req_wdata, e_wdata);
                    end
                end
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i < lat; i++) begin
                checks++;
                if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL %s wait[%0d]: mem_req_valid=%b rsp_valid=%b want 0 0",
                                       tag, i, mem_req_valid, rsp_valid);
                end
                @(negedge clk);
            end
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rword; mem_rsp_err = berr;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_rdata = $urandom;
        end else begin
            checks++;
            if (mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL %s no_bus: mem_req_valid=%b want 0", tag, mem_req_valid);
            end
        end

        for (int i = 0; i <= hold; i++) begin
            rsp_ready = (i == hold);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== e_data || rsp_err !== e_err) begin
                errors++;
                $display("FAIL %s resp[%0d]: valid=%b req_ready=%b data=%h err=%b want 1 0 %h %b",
                         tag, i, rsp_valid, req_ready, rsp_data, rsp_err, e_data, e_err);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s back_idle: rsp_valid=%b req_ready=%b want 0 1", tag, rsp_valid, req_ready);
        end
    endtask

    // ---------------- XLEN=64 access driver ----------------
    task automatic access64(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [63:0] rw, input string tag);
        bit          bad;
        int unsigned off;
        logic [7:0]  e_strb;
        logic [63:0] e_wd, e_data;
        bad    = m_bad(f3, addr, 64);
        off    = m_off(f3, addr, 64);
        e_strb = 8'(m_strb(f3, off));
        e_wd   = wd << (8 * off);
        e_data = (st || bad) ? 64'h0 : m_load(f3, rw, off);

        b_req_valid = 1'b1; b_req_is_store = st; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        @(negedge clk);
        b_req_valid = 1'b0;
        if (!bad) begin
            b_mem_req_ready = 1'b1;
            checks++;
            if (b_mem_req_valid !== 1'b1 || b_mem_req_addr !== (addr & 32'hFFFF_FFF8) ||
                b_mem_req_wstrb !== e_strb || (st && b_mem_req_wdata !== e_wd)) begin
                errors++;
                $display("FAIL %s bus64: valid=%b addr=%h strb=%h wdata=%h want 1 %h %h %h",
                         tag, b_mem_req_valid, b_mem_req_addr, b_mem_req_wstrb, b_mem_req_wdata,
                         addr & 32'hFFFF_FFF8, e_strb, e_wd);
            end
            @(negedge clk);
            b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b1; b_mem_rsp_rdata = rw;
            @(negedge clk);
            b_mem_rsp_valid = 1'b0;
        end
        b_rsp_ready = 1'b1;
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_data !== e_data || b_rsp_err !== bad) begin
            errors++;
            $display("FAIL %s resp64: valid=%b data=%h err=%b want 1 %h %b",
                     tag, b_rsp_valid, b_rsp_data, b_rsp_err, e_data, bad);
        end
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_wen !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_err !== 1'b0 || rsp_data !== 32'h0 || mem_req_wstrb !== 4'h0 || mem_req_wdata !== 32'h0 ||
            mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b mv=%b wen=%b rv=%b err=%b data=%h strb=%h wd=%h addr=%h want 1 0 0 0 0 0 0 0 0",
                     req_ready, mem_req_valid, mem_req_wen, rsp_valid, rsp_err, rsp_data,
                     mem_req_wstrb, mem_req_wdata, mem_req_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: rdy=%b rv=%b rdy64=%b rv64=%b want 1 0 1 0",
                               req_ready, rsp_valid, b_req_ready, b_rsp_valid);
        end
    endtask

    task automatic test_store_word();
        access(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, 0, "sw_min_latency");
    endtask

    task automatic test_byte_loads();
        access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, 0, "lb_signed");
        access(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, 0, "lbu_zero");
        access(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8123_4567, 1'b0, 0, 1, 0, "lh_signed");
        access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8123_4567, 1'b0, 0, 0, 1, "lhu_zero");
    endtask

    task automatic test_req_stall();
        access(1'b1, 3'b001, 32'h8000_0102, 32'h0000_1234, 32'h0, 1'b0, 3, 0, 0, "sh_stall3");
    endtask

    task automatic test_misalign();
        access(1'b0, 3'b010, 32'h8000_0012, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 0, "lw_misaligned");
        access(1'b1, 3'b001, 32'h8000_0021, 32'hABCD_5678, 32'h0, 1'b0, 0, 0, 0, "sh_misaligned");
    endtask

    task automatic test_illegal();
        access(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h1111_1111, 1'b0, 0, 0, 0, "ld_on_rv32");
        access(1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h2222_2222, 1'b0, 0, 0, 1, "lwu_on_rv32");
        access(1'b1, 3'b111, 32'h8000_0000, 32'h3333_3333, 32'h0, 1'b0, 0, 0, 0, "f3_111");
    endtask

    task automatic test_bus_error();
        access(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h7654_3210, 1'b1, 0, 0, 4, "load_bus_err");
        access(1'b1, 3'b010, 32'h8000_0044, 32'h1357_9BDF, 32'h0, 1'b1, 1, 1, 0, "store_bus_err");
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0080;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            mem_req_wstrb !== 4'h0 || mem_req_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mid: rdy=%b mv=%b rv=%b err=%b strb=%h addr=%h want 1 0 0 0 0 0",
                               req_ready, mem_req_valid, rsp_valid, rsp_err, mem_req_wstrb, mem_req_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF; mem_rsp_err = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL late_rsp_ignored: rv=%b rdy=%b data=%h err=%b want 0 1 0 0",
                               rsp_valid, req_ready, rsp_data, rsp_err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          st;
            logic [2:0]  f3;
            st = 1'($urandom);
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            access(st, f3, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] w;
        w = {$urandom, $urandom} | 64'h8000_0000_8000_0000;
        access64(1'b0, 3'b011, 32'h8000_0008, 64'h0, w, "ld64_pass");
        access64(1'b1, 3'b011, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, "sd64");
        access64(1'b0, 3'b010, 32'h8000_000C, 64'h0, w, "lw64_sext");
        access64(1'b0, 3'b110, 32'h8000_000C, 64'h0, w, "lwu64_zext");
        access64(1'b0, 3'b000, 32'h8000_000F, 64'h0, w, "lb64");
        access64(1'b1, 3'b010, 32'h8000_0024, 64'h0000_0000_A5A5_5A5A, 64'h0, "sw64_upper");
        access64(1'b0, 3'b111, 32'h8000_0000, 64'h0, w, "f3_111_64");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_word();
        test_byte_loads();
        test_req_stall();
        test_misalign();
        test_illegal();
        test_bus_error();
        test_reset_mid();
        test_random();
        test_xlen64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
